// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for a SIZE x SIZE systolic MAC array: config, lane-FIFO load, skewed
// streaming, PE drain and row-by-row result handout, with a synchronous abort.
module systolic_tile_ctrl #(
  parameter int SIZE      = 4,
  parameter int DEPTH     = 8,
  parameter int DRAIN_CYC = 2*SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_val,
  output logic                       cfg_rdy,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_k,
  input  logic                       abort,
  input  logic                       x_send_val,
  output logic                       x_send_rdy,
  input  logic                       w_send_val,
  output logic                       w_send_rdy,
  input  logic [SIZE-1:0]            x_fifo_full,
  input  logic [SIZE-1:0]            x_fifo_empty,
  input  logic [SIZE-1:0]            w_fifo_full,
  input  logic [SIZE-1:0]            w_fifo_empty,
  output logic [SIZE-1:0]            x_fifo_wen,
  output logic [SIZE-1:0]            w_fifo_wen,
  output logic [SIZE-1:0]            x_fifo_ren,
  output logic [SIZE-1:0]            w_fifo_ren,
  output logic                       fifo_clr,
  output logic                       mac_en,
  output logic                       acc_clr,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(SIZE)-1:0]    out_row,
  output logic                       tile_done,
  output logic [2:0]                 trace_state
);

  localparam int KW = $clog2(DEPTH+1);
  localparam int RW = $clog2(SIZE);
  localparam int DW = $clog2(DRAIN_CYC+1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d, x_cnt_q, x_cnt_d, w_cnt_q, w_cnt_d, iss_cnt_q, iss_cnt_d;
  logic [SIZE-1:0] ren_q, ren_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [RW-1:0]   row_q, row_d;
  logic            acc_clr_q, acc_clr_d, done_q, done_d, fclr_q, fclr_d;
  logic            x_fire, w_fire, issue;
  logic [KW-1:0]   k_clamp;

  // Empty flags are only observed externally; the read schedule never consults them.
  logic unused_empty;
  assign unused_empty = ^{x_fifo_empty, w_fifo_empty};

  always_comb begin
    k_clamp = cfg_k;
    if (cfg_k == '0)            k_clamp = KW'(1);
    else if (cfg_k > KW'(DEPTH)) k_clamp = KW'(DEPTH);
  end

  assign cfg_rdy    = ~rst & ~abort & (state_q == IDLE);
  assign x_send_rdy = ~rst & ~abort & (state_q == LOAD) & (x_cnt_q < k_q) & ~|x_fifo_full;
  assign w_send_rdy = ~rst & ~abort & (state_q == LOAD) & (w_cnt_q < k_q) & ~|w_fifo_full;
  assign x_fire     = x_send_val & x_send_rdy;
  assign w_fire     = w_send_val & w_send_rdy;
  assign x_fifo_wen = {SIZE{x_fire}};
  assign w_fifo_wen = {SIZE{w_fire}};
  assign x_fifo_ren = ren_q;
  assign w_fifo_ren = ren_q;
  assign fifo_clr   = fclr_q;
  assign acc_clr    = acc_clr_q;
  assign tile_done  = done_q;
  assign out_val    = (state_q == OUT);
  assign out_row    = row_q;
  assign trace_state = state_q;
  // PEs accumulate while any lane is streaming and through the whole drain window.
  assign mac_en     = ((state_q == MAC) & (|ren_q)) | (state_q == DRAIN);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_cnt_d   = x_cnt_q + KW'(x_fire);
    w_cnt_d   = w_cnt_q + KW'(w_fire);
    iss_cnt_d = iss_cnt_q;
    ren_d     = ren_q;
    drain_d   = drain_q;
    row_d     = row_q;
    acc_clr_d = 1'b0;
    done_d    = 1'b0;
    fclr_d    = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_val) begin
          k_d     = k_clamp;
          x_cnt_d = '0;
          w_cnt_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (x_cnt_d == k_q && w_cnt_d == k_q) begin
          state_d   = MAC;
          ren_d     = '0;
          iss_cnt_d = '0;
        end
      end
      MAC: begin
        // Lane 0 issues k reads; higher lanes replay it one cycle later each.
        issue     = (iss_cnt_q < k_q);
        iss_cnt_d = iss_cnt_q + KW'(issue);
        ren_d     = {ren_q[SIZE-2:0], issue};
        if (ren_q[SIZE-1] && !ren_d[SIZE-1]) begin
          state_d = DRAIN;
          ren_d   = '0;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DRAIN_CYC-1)) begin
          state_d = OUT;
          row_d   = '0;
        end
      end
      OUT: begin
        if (out_rdy) begin
          if (row_q == RW'(SIZE-1)) begin
            state_d   = IDLE;
            acc_clr_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      ren_d     = '0;
      x_cnt_d   = '0;
      w_cnt_d   = '0;
      iss_cnt_d = '0;
      drain_d   = '0;
      row_d     = '0;
      done_d    = 1'b0;
      acc_clr_d = 1'b1;
      fclr_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      x_cnt_q   <= '0;
      w_cnt_q   <= '0;
      iss_cnt_q <= '0;
      ren_q     <= '0;
      drain_q   <= '0;
      row_q     <= '0;
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      fclr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_cnt_q   <= x_cnt_d;
      w_cnt_q   <= w_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      ren_q     <= ren_d;
      drain_q   <= drain_d;
      row_q     <= row_d;
      acc_clr_q <= acc_clr_d;
      done_q    <= done_d;
      fclr_q    <= fclr_d;
    end
  end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboarded bench for systolic_tile_ctrl: directed tiles push expected per-tile
// activity and result rows; a negedge monitor pops and compares as the DUT produces them.
module tb_systolic_tile_ctrl;
  localparam int SIZE = 4;
  localparam int DEPTH = 8;
  localparam int DRAIN_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_val = 1'b0;
  logic cfg_rdy;
  logic [3:0] cfg_k = '0;
  logic abort = 1'b0;
  logic x_send_val = 1'b0, w_send_val = 1'b0;
  logic x_send_rdy, w_send_rdy;
  logic [SIZE-1:0] x_fifo_full, x_fifo_empty, w_fifo_full, w_fifo_empty;
  logic [SIZE-1:0] x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren;
  logic fifo_clr, mac_en, acc_clr, out_val, tile_done;
  logic out_rdy;
  logic [1:0] out_row;
  logic [2:0] trace_state;
  logic [SIZE-1:0] force_x_full = '0;
  logic tog_en = 1'b0;

  always #5 clk = ~clk;

  systolic_tile_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_k(cfg_k),
    .abort(abort), .x_send_val(x_send_val), .x_send_rdy(x_send_rdy),
    .w_send_val(w_send_val), .w_send_rdy(w_send_rdy),
    .x_fifo_full(x_fifo_full), .x_fifo_empty(x_fifo_empty),
    .w_fifo_full(w_fifo_full), .w_fifo_empty(w_fifo_empty),
    .x_fifo_wen(x_fifo_wen), .w_fifo_wen(w_fifo_wen),
    .x_fifo_ren(x_fifo_ren), .w_fifo_ren(w_fifo_ren),
    .fifo_clr(fifo_clr), .mac_en(mac_en), .acc_clr(acc_clr),
    .out_val(out_val), .out_rdy(out_rdy), .out_row(out_row),
    .tile_done(tile_done), .trace_state(trace_state)
  );

  // Lane FIFO occupancy model feeding full/empty back to the controller.
  int xocc[SIZE];
  int wocc[SIZE];
  always @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (rst || fifo_clr) begin
        xocc[i] <= 0;
        wocc[i] <= 0;
      end else begin
        xocc[i] <= xocc[i] + int'(x_fifo_wen[i]) - int'(x_fifo_ren[i]);
        wocc[i] <= wocc[i] + int'(w_fifo_wen[i]) - int'(w_fifo_ren[i]);
      end
    end
  end
  always_comb begin
    x_fifo_empty = '0;
    w_fifo_empty = '0;
    x_fifo_full  = force_x_full;
    w_fifo_full  = '0;
    for (int i = 0; i < SIZE; i++) begin
      x_fifo_empty[i] = (xocc[i] <= 0);
      w_fifo_empty[i] = (wocc[i] <= 0);
      if (xocc[i] >= DEPTH) x_fifo_full[i] = 1'b1;
      if (wocc[i] >= DEPTH) w_fifo_full[i] = 1'b1;
    end
  end

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = tog_en ? ~out_rdy : 1'b1;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int  wen;
    int  ren;
    int  mac;
    int  rows;
    bit  aborted;
  } exp_t;
  exp_t exp_q[$];
  int   row_q[$];

  task automatic push_tile(input int wen, input int ren, input int mac, input int rows,
                           input bit ab);
    exp_t e;
    e.wen = wen; e.ren = ren; e.mac = mac; e.rows = rows; e.aborted = ab;
    exp_q.push_back(e);
    for (int r = 0; r < rows; r++) row_q.push_back(r);
  endtask

  // Monitor: per-tile activity counters, closed out on tile_done or fifo_clr.
  int cyc = 0, xw = 0, ww = 0, r0 = 0, r3 = 0, r0_first = 0, r3_first = 0;
  int mac = 0, hs = 0, tiles_ended = 0;
  bit under = 0, renmis = 0, bad_wen = 0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      cyc++;
      if (x_fifo_wen != '0) begin xw++; if (x_fifo_wen != '1) bad_wen = 1; end
      if (w_fifo_wen != '0) begin ww++; if (w_fifo_wen != '1) bad_wen = 1; end
      if (x_fifo_ren != w_fifo_ren) renmis = 1;
      if (x_fifo_ren[0]) begin if (r0 == 0) r0_first = cyc; r0++; end
      if (x_fifo_ren[SIZE-1]) begin if (r3 == 0) r3_first = cyc; r3++; end
      if (((x_fifo_ren & x_fifo_empty) != '0) || ((w_fifo_ren & w_fifo_empty) != '0)) under = 1;
      if (mac_en) mac++;
      if (out_val) begin
        chk("out_row_vs_handshakes", int'(out_row), hs);
        if (out_rdy) begin
          chk("row_queue_nonempty", int'(row_q.size() > 0), 1);
          if (row_q.size() > 0) chk("out_row_handshake", int'(out_row), row_q.pop_front());
          hs++;
        end
      end
      if (tile_done || fifo_clr) begin
        chk("exp_queue_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tile_done", int'(tile_done), int'(!e.aborted));
          chk("fifo_clr", int'(fifo_clr), int'(e.aborted));
          chk("acc_clr", int'(acc_clr), 1);
          chk("x_wen_cycles", xw, e.wen);
          chk("w_wen_cycles", ww, e.wen);
          chk("ren0_cycles", r0, e.ren);
          chk("mac_en_cycles", mac, e.mac);
          chk("rows_out", hs, e.rows);
          chk("empty_read", int'(under), 0);
          chk("ren_x_w_equal", int'(renmis), 0);
          chk("wen_all_lanes", int'(bad_wen), 0);
          if (!e.aborted) begin
            chk("ren3_cycles", r3, e.ren);
            chk("ren3_skew", r3_first - r0_first, SIZE-1);
          end
        end
        xw = 0; ww = 0; r0 = 0; r3 = 0; mac = 0; hs = 0;
        under = 0; renmis = 0; bad_wen = 0;
        tiles_ended++;
      end
    end
  end

  task automatic send_cfg(input int k);
    cfg_val = 1'b1;
    cfg_k = 4'(k);
    @(posedge clk);
    #1;
    cfg_val = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int start;
    int n;
    start = tiles_ended;
    n = 0;
    while (tiles_ended == start && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({nm, "_completed"}, int'(tiles_ended != start), 1);
  endtask

  initial begin
    int n;
    // Reset
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cfg_rdy", int'(cfg_rdy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    x_send_val = 1'b1;
    w_send_val = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(trace_state), 0);
    chk("rst_cfg_rdy_idle", int'(cfg_rdy), 1);
    chk("rst_wen", int'({x_fifo_wen, w_fifo_wen}), 0);
    chk("rst_ren", int'({x_fifo_ren, w_fifo_ren}), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_tile_done", int'(tile_done), 0);
    @(posedge clk); #1;

    // k=3 baseline
    push_tile(3, 3, 14, 4, 0);
    send_cfg(3);
    wait_end("k3");

    // k=0 clamps to 1
    push_tile(1, 1, 12, 4, 0);
    send_cfg(0);
    wait_end("k0");

    // k=12 clamps to 8
    push_tile(8, 8, 19, 4, 0);
    send_cfg(12);
    wait_end("k12");

    // x lane 2 full stalls x only; w keeps loading
    force_x_full = 4'b0100;
    push_tile(4, 4, 15, 4, 0);
    send_cfg(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_x_rdy", int'(x_send_rdy), 0);
      chk("full_w_rdy", int'(w_send_rdy), 1);
      chk("full_x_wen", int'(x_fifo_wen), 0);
      @(posedge clk); #1;
    end
    force_x_full = '0;
    wait_end("full");

    // out_rdy toggling
    tog_en = 1'b1;
    push_tile(2, 2, 13, 4, 0);
    send_cfg(2);
    wait_end("toggle");
    tog_en = 1'b0;
    @(posedge clk); #1;

    // abort in the second lane-0 read cycle, then a back-to-back k=2 tile
    push_tile(3, 2, 2, 0, 1);
    send_cfg(3);
    n = 0;
    @(negedge clk);
    while (!x_fifo_ren[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_ren_seen", int'(x_fifo_ren[0]), 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    push_tile(2, 2, 13, 4, 0);
    cfg_val = 1'b1;
    cfg_k = 4'd2;
    @(negedge clk);
    chk("abort_state", int'(trace_state), 0);
    chk("abort_fifo_clr", int'(fifo_clr), 1);
    chk("abort_acc_clr", int'(acc_clr), 1);
    chk("abort_ren", int'({x_fifo_ren, w_fifo_ren}), 0);
    chk("abort_no_done", int'(tile_done), 0);
    chk("abort_cfg_rdy", int'(cfg_rdy), 1);
    @(posedge clk); #1;
    cfg_val = 1'b0;
    wait_end("after_abort");

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("row_queue_drained", row_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
